// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared types, font and helpers for the seven-segment debug driver
package ssd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } conv_state_e;

    localparam logic MODE_HEX = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Active-high font, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_font(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = SEG_0;
            4'h1:    s = SEG_1;
            4'h2:    s = SEG_2;
            4'h3:    s = SEG_3;
            4'h4:    s = SEG_4;
            4'h5:    s = SEG_5;
            4'h6:    s = SEG_6;
            4'h7:    s = SEG_7;
            4'h8:    s = SEG_8;
            4'h9:    s = SEG_9;
            4'hA:    s = SEG_A;
            4'hB:    s = SEG_B;
            4'hC:    s = SEG_C;
            4'hD:    s = SEG_D;
            4'hE:    s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

endpackage

// File: rtl/ssd_bcd_converter.sv
// rtl/ssd_bcd_converter.sv - sequential double-dabble binary to BCD converter
module ssd_bcd_converter
    import ssd_pkg::*;
#(
    parameter int BIN_W = 13,
    parameter int BCD_W = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    conv_state_e      state_q, state_d;
    logic [BIN_W-1:0] sr_q;
    logic [BCD_W-1:0] field_q;
    logic [BCD_W-1:0] adj;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(BIN_W - 1)) state_d = LATCH;
            LATCH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    always_comb begin
        adj = field_q;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (field_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = field_q[4*i +: 4] + 4'd3;
        end
    end

    // Carries out of the top BCD nibble are dropped; the caller flags that case as overflow
    always_ff @(posedge clk) begin
        if (Reset) begin
            sr_q    <= '0;
            field_q <= '0;
            cnt_q   <= '0;
            bcd     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sr_q    <= bin;
                        field_q <= '0;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    field_q <= {adj[BCD_W-2:0], sr_q[BIN_W-1]};
                    sr_q    <= sr_q << 1;
                    cnt_q   <= cnt_q + CNT_W'(1);
                end
                LATCH: begin
                    bcd  <= field_q;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ssd_debug_driver.sv
// rtl/ssd_debug_driver.sv - multiplexed seven-segment debug display with hex/decimal modes
module ssd_debug_driver
    import ssd_pkg::*;
#(
    parameter int DATA_W         = 13,
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int BLANK_LZ       = 1
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] value,
    input  logic              value_valid,
    input  logic              mode,
    output logic [DIGITS-1:0] anode,
    output logic [6:0]        segments,
    output logic              busy,
    output logic              overflow
);

    localparam int          BCD_W     = 4 * DIGITS;
    localparam int          HEX_W     = (DATA_W > BCD_W) ? DATA_W : BCD_W;
    localparam int          IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int          CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [63:0] DEC_LIMIT = pow10(DIGITS);
    localparam bit          POL       = (SEG_ACTIVE_LOW != 0);

    logic             accept, start_dec, load_hex;
    logic             conv_busy, conv_done;
    logic [BCD_W-1:0] conv_bcd;
    logic [HEX_W-1:0] val_ext;
    logic             hex_ovf, dec_ovf_now;

    logic [BCD_W-1:0]  disp_q;
    logic              loaded_q, ovf_q, pend_ovf_q;
    logic [DIGITS-1:0] shown;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [3:0]        cur_nib;
    logic              cur_shown;
    logic [6:0]        seg_raw;
    logic [DIGITS-1:0] anode_raw;

    assign accept      = value_valid && !conv_busy;
    assign start_dec   = accept && (mode == MODE_DEC);
    assign load_hex    = accept && (mode == MODE_HEX);
    assign val_ext     = HEX_W'(value);
    assign hex_ovf     = (val_ext >> BCD_W) != '0;
    assign dec_ovf_now = 64'(value) >= DEC_LIMIT;
    assign busy        = conv_busy;
    assign overflow    = ovf_q;

    ssd_bcd_converter #(
        .BIN_W (DATA_W),
        .BCD_W (BCD_W)
    ) u_conv (
        .clk   (clk),
        .Reset (Reset),
        .start (start_dec),
        .bin   (value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // A hex accept on the edge right after LATCH is the newer value, so it beats the conversion result
    always_ff @(posedge clk) begin
        if (Reset) begin
            disp_q     <= '0;
            loaded_q   <= 1'b0;
            ovf_q      <= 1'b0;
            pend_ovf_q <= 1'b0;
        end else begin
            if (start_dec) pend_ovf_q <= dec_ovf_now;
            if (load_hex) begin
                disp_q   <= val_ext[BCD_W-1:0];
                loaded_q <= 1'b1;
                ovf_q    <= hex_ovf;
            end else if (conv_done) begin
                disp_q   <= conv_bcd;
                loaded_q <= 1'b1;
                ovf_q    <= pend_ovf_q;
            end
        end
    end

    always_comb begin
        logic nz_seen;
        nz_seen = 1'b0;
        shown   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz_seen  = nz_seen || (disp_q[4*i +: 4] != 4'd0);
            shown[i] = loaded_q && (nz_seen || (i == 0) || (BLANK_LZ == 0));
        end
    end

    always_comb begin
        cur_nib   = 4'd0;
        cur_shown = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = disp_q[4*i +: 4];
                cur_shown = shown[i];
            end
        end
        if (ovf_q)           seg_raw = SEG_DASH;
        else if (!cur_shown) seg_raw = SEG_BLANK;
        else                 seg_raw = seg_font(cur_nib);
        anode_raw = DIGITS'(1) << idx_q;
    end

    // The lit digit is the index before it advances, so digit 0 shows first after reset
    always_ff @(posedge clk) begin
        if (Reset) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            anode    <= {DIGITS{POL}};
            segments <= {7{POL}};
        end else if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_q    <= '0;
            idx_q    <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            anode    <= anode_raw ^ {DIGITS{POL}};
            segments <= seg_raw ^ {7{POL}};
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ssd_debug_driver.sv
// tb/tb_ssd_debug_driver.sv - directed self-checking bench for ssd_debug_driver
module tb_ssd_debug_driver;

    logic        clk;
    logic        Reset;
    logic [12:0] value;
    logic        value_valid;
    logic        valid3;
    logic        mode;
    logic [3:0]  anode;
    logic [6:0]  segments;
    logic        busy;
    logic        overflow;
    logic [2:0]  an3;
    logic [6:0]  seg3;
    logic        busy3;
    logic        ovf3;

    int n_checks = 0;
    int n_fail   = 0;

    ssd_debug_driver #(
        .DATA_W(13), .DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1), .BLANK_LZ(1)
    ) dut (
        .clk(clk), .Reset(Reset), .value(value), .value_valid(value_valid), .mode(mode),
        .anode(anode), .segments(segments), .busy(busy), .overflow(overflow)
    );

    ssd_debug_driver #(
        .DATA_W(13), .DIGITS(3), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1), .BLANK_LZ(1)
    ) dut3 (
        .clk(clk), .Reset(Reset), .value(value), .value_valid(valid3), .mode(mode),
        .anode(an3), .segments(seg3), .busy(busy3), .overflow(ovf3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [12:0] v, input logic m);
        value       = v;
        mode        = m;
        value_valid = 1'b1;
        step(1);
        value_valid = 1'b0;
    endtask

    task automatic busy_len(input string tag, input int exp);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            step(1);
        end
        check(tag, n, exp);
    endtask

    task automatic wait_anode(input string tag, input logic [3:0] target);
        int n;
        n = 0;
        while (anode === target && n < 64) begin
            n++;
            step(1);
        end
        while (anode !== target && n < 64) begin
            n++;
            step(1);
        end
        check(tag, anode, target);
    endtask

    task automatic check_digit(input string tag, input logic [3:0] an, input logic [6:0] seg);
        int stay;
        check({tag, "_an"}, anode, an);
        check({tag, "_seg"}, segments, seg);
        stay = 0;
        while (anode === an && stay < 16) begin
            stay++;
            step(1);
        end
        check({tag, "_stay"}, stay, 4);
    endtask

    initial begin
        logic [2:0] seen;
        Reset       = 1'b1;
        value       = '0;
        value_valid = 1'b0;
        valid3      = 1'b0;
        mode        = 1'b0;

        // Reset state and first refresh tick
        step(2);
        check("rst_anode", anode, 4'b1111);
        check("rst_seg", segments, 7'b1111111);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        Reset = 1'b0;
        step(3);
        check("pre_tick_anode", anode, 4'b1111);
        step(1);
        check("first_tick_anode", anode, 4'b1110);
        check("first_tick_seg", segments, 7'b1111111);

        // Decimal 1234
        accept(13'd1234, 1'b1);
        check("dec_busy_on", busy, 1'b1);
        busy_len("dec_busy_len", 14);
        step(1);
        check("dec_ovf", overflow, 1'b0);
        wait_anode("dec_reach", 4'b1110);
        check_digit("dec_d0", 4'b1110, 7'b0011001);
        check_digit("dec_d1", 4'b1101, 7'b0110000);
        check_digit("dec_d2", 4'b1011, 7'b0100100);
        check_digit("dec_d3", 4'b0111, 7'b1111001);

        // Hex 01A3, accepted one edge before a tick to expose load latency
        step(2);
        accept(13'h01A3, 1'b0);
        check("hex_busy", busy, 1'b0);
        step(1);
        check_digit("hex_d1", 4'b1101, 7'b0001000);
        check_digit("hex_d2", 4'b1011, 7'b1111001);
        check_digit("hex_d3", 4'b0111, 7'b1111111);
        check_digit("hex_d0", 4'b1110, 7'b0110000);
        check("hex_ovf", overflow, 1'b0);

        // Accept while busy is dropped
        accept(13'd1234, 1'b1);
        step(4);
        value       = 13'd5678;
        value_valid = 1'b1;
        step(1);
        value_valid = 1'b0;
        busy_len("drop_busy_len", 9);
        step(1);
        wait_anode("drop_reach", 4'b1110);
        check_digit("drop_d0", 4'b1110, 7'b0011001);
        check_digit("drop_d1", 4'b1101, 7'b0110000);
        check_digit("drop_d2", 4'b1011, 7'b0100100);
        check_digit("drop_d3", 4'b0111, 7'b1111001);

        // Reset mid-conversion, then decimal zero
        accept(13'd1234, 1'b1);
        step(6);
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_anode", anode, 4'b1111);
        check("abort_seg", segments, 7'b1111111);
        accept(13'd0, 1'b1);
        busy_len("zero_busy_len", 14);
        step(1);
        wait_anode("zero_reach", 4'b1110);
        check_digit("zero_d0", 4'b1110, 7'b1000000);
        check_digit("zero_d1", 4'b1101, 7'b1111111);
        check_digit("zero_d2", 4'b1011, 7'b1111111);
        check_digit("zero_d3", 4'b0111, 7'b1111111);

        // Three-digit instance: overflow boundaries and dash display
        value  = 13'd999;
        mode   = 1'b1;
        valid3 = 1'b1;
        step(1);
        valid3 = 1'b0;
        step(15);
        check("d3_999_ovf", ovf3, 1'b0);
        value  = 13'd8191;
        valid3 = 1'b1;
        step(1);
        valid3 = 1'b0;
        step(15);
        check("d3_8191_ovf", ovf3, 1'b1);
        step(4);
        seen = 3'b000;
        for (int i = 0; i < 12; i++) begin
            check("d3_dash_seg", seg3, 7'b0111111);
            seen = seen | ~an3;
            step(1);
        end
        check("d3_dash_digits", seen, 3'b111);
        value  = 13'h0FFF;
        mode   = 1'b0;
        valid3 = 1'b1;
        step(1);
        check("d3_hex_fff_ovf", ovf3, 1'b0);
        value = 13'h1000;
        step(1);
        valid3 = 1'b0;
        check("d3_hex_1000_ovf", ovf3, 1'b1);
        check("d3_hex_busy", busy3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ssd_debug_driver.md
Name: ssd_debug_driver

Overview:
- Parametrised seven-segment debug display driver for the processor top level.
- Successor to the fixed 13-bit SSD path: configurable digit count, refresh rate, hex or decimal mode, leading-zero blanking and overflow indication.
- Accepts a sampled debug value from the datapath, converts it to digits (sequential double-dabble in decimal mode) and time-multiplexes the digits onto the anode and segment pins.

Parameters:
- DATA_W, 13: width of the debug value input.
- DIGITS, 4: number of display digits; valid range 1–8.
- REFRESH_DIV, 100000: clk cycles each digit stays lit; must be ≥ 2.
- SEG_ACTIVE_LOW, 1: 1 means segments and anodes are driven active-low.
- BLANK_LZ, 1: 1 enables leading-zero blanking.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- Reset, input, 1: synchronous, active-high reset.
- value, input, DATA_W: value to display, unsigned.
- value_valid, input, 1: load strobe; sampled only when busy=0.
- mode, input, 1: 0 = hex, 1 = decimal; sampled at accept.
- anode, output, DIGITS: one-hot digit enable.
- segments, output, 7: {g,f,e,d,c,b,a}.
- busy, output, 1: decimal conversion in progress.
- overflow, output, 1: displayed value does not fit in DIGITS digits.

Behaviour:
- Reset values, applied on the first rising clk edge with Reset=1:
  - anode all inactive, segments all inactive (all 1s when SEG_ACTIVE_LOW).
  - busy=0, overflow=0, FSM in IDLE, refresh counter and digit index 0, display register all blank.
- Accept: value_valid=1 && busy=0 on a rising edge. value_valid while busy=1 is dropped, with no queuing.
- Hex mode:
  - Display register loads nibbles of value on the accept edge; latency is 1 cycle and busy stays 0.
  - If DATA_W > 4*DIGITS, upper bits are truncated and overflow=1 when any truncated bit is nonzero.
- Decimal mode FSM, states IDLE → SHIFT → LATCH → IDLE:
  - IDLE: on accept, capture value into the shift register, clear the BCD field and go to SHIFT. busy=1 from the next cycle.
  - SHIFT: exactly DATA_W cycles. Each cycle, first add 3 to every BCD nibble ≥ 5, then shift left 1.
  - LATCH: copy the BCD field to the display register. overflow = (captured value ≥ 10^DIGITS), computed at accept against a compile-time constant. Go to IDLE with busy=0.
  - Display updates DATA_W+2 edges after the accept edge.
  - BCD field is 4*DIGITS bits. Out-of-range carries are discarded; the overflow flag covers that case.
- Overflow display: while overflow=1, every digit shows a dash (g only), ignoring blanking.
- Leading-zero blanking (BLANK_LZ=1): digits above the most-significant nonzero digit are blank. Digit 0 is always shown, so value 0 displays a single "0".
- Refresh:
  - Counter runs 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the digit index advances modulo DIGITS (index DIGITS-1 → 0).
  - anode and segments are registered from the digit index and display register, updating on the same edge as the index.
  - After reset, outputs stay inactive until the first terminal count. From then on digit 0 is lit, followed by 1, 2, …
- Segment font: hex 0–F, dash, blank. Polarity is applied last: inverted when SEG_ACTIVE_LOW=1.
- Simultaneous events:
  - A refresh tick during LATCH shows the new digits from the next tick onward.
  - A new accept may occur on the edge immediately after LATCH.
- Reset mid-conversion aborts: FSM returns to IDLE, busy=0, display cleared. Reset dominates value_valid.

Decomposition:
- Package ssd_pkg holds:
  - FSM state encoding (IDLE, SHIFT, LATCH).
  - Seven-segment font constants for 0–F, DASH and BLANK in active-high form.
  - Mode encodings MODE_HEX=0, MODE_DEC=1.
- Sub-module ssd_bcd_converter: the double-dabble FSM.
  - Ports: clk, Reset, start, bin, busy, done, bcd.
- Top block: accept logic, overflow, blanking, refresh counter and anode/segment output registers.

Test Plan:
All scenarios use DATA_W=13, DIGITS=4, REFRESH_DIV=4, SEG_ACTIVE_LOW=1, BLANK_LZ=1 unless stated.
1. Reset held 2 cycles, then released → anode=4'b1111, segments=7'b1111111, busy=0 until the first tick. Four edges after release, anode=4'b1110.
2. Decimal, value=1234:
   - busy=1 for 14 cycles after accept.
   - Display shows 4, 3, 2, 1 on anodes 1110, 1101, 1011, 0111, each for 4 cycles.
   - Segments for "4" = 7'b0011001; overflow=0.
3. Hex, value=13'h01A3:
   - Digits are 3, A, 1, blank; digit 3 shows segments 7'b1111111.
   - busy never asserts; display updates 1 cycle after accept.
4. DIGITS=3, decimal, value=8191 → overflow=1 and all three digits show 7'b0111111 (dash).
5. Accept 1234 (decimal), pulse value_valid with 5678 at cycle 5 → 5678 is ignored and the display shows 1234.
6. Reset asserted at cycle 7 of the 1234 conversion → busy=0 next cycle and display blank. Then accept value=0 in decimal → only digit 0 shows 7'b1000000.
